// File: rtl/rcu_pkg.sv
// Shared RCU types and constants for the clock configuration sequencer.
package rcu_pkg;

  localparam int unsigned RCU_CLK_CFG_WIDTH  = 3;
  localparam int unsigned RCU_CORE_SEL_WIDTH = 5;

  // clk_cfg encoding that selects bypass clocking (PLL not used)
  localparam logic [RCU_CLK_CFG_WIDTH-1:0] CLK_CFG_BYPASS = 3'b000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UNWIND,
    ST_PLL_ON,
    ST_WAIT_LOCK,
    ST_SWITCH,
    ST_CONFIRM,
    ST_DONE,
    ST_FAIL
  } rcu_seq_state_e;

  // A configuration needs the PLL whenever it is not the bypass encoding
  function automatic logic pll_used(input logic [RCU_CLK_CFG_WIDTH-1:0] cfg);
    return cfg != CLK_CFG_BYPASS;
  endfunction

endpackage

// File: rtl/rcu_lock_filt.sv
// Debounce of the raw PLL lock: lock is declared once pll_lock has been
// seen high for LOCK_FILT consecutive sampled cycles. clr_i holds the run at 0.
module rcu_lock_filt #(
  parameter int unsigned LOCK_FILT = 4
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clr_i,
  input  logic lock_raw_i,
  output logic lock_o
);

  localparam int unsigned FW = $clog2(LOCK_FILT + 1);
  localparam logic [FW-1:0] RUN_MAX = FW'(LOCK_FILT);

  logic [FW-1:0] run_q;
  logic [FW-1:0] run_d;

  // Run length of consecutive high samples, saturating at LOCK_FILT
  always_comb begin
    run_d = '0;
    if (!clr_i && lock_raw_i) begin
      run_d = (run_q == RUN_MAX) ? run_q : run_q + FW'(1);
    end
  end

  // Run length register with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      run_q <= '0;
    end else begin
      run_q <= run_d;
    end
  end

  // Asserted in the cycle whose sample completes the run, so the sequencer
  // can leave WAIT_LOCK on the same edge the filter reaches LOCK_FILT.
  assign lock_o = (run_d == RUN_MAX);

endmodule

// File: rtl/rcu_cfg_seq.sv
// RCU clock configuration sequencer: enables the PLL, waits for a filtered
// lock, applies clk_cfg/core_sel, confirms via the core_sel echo, and falls
// back to bypass clocking on any failure. All outputs are registered.
module rcu_cfg_seq
  import rcu_pkg::*;
#(
  parameter int unsigned LOCK_TIMEOUT = 1024,
  parameter int unsigned LOCK_FILT    = 4,
  parameter int unsigned SETTLE_CYC   = 16,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          req_i,
  input  logic [RCU_CLK_CFG_WIDTH-1:0]  cfg_clk_i,
  input  logic [RCU_CORE_SEL_WIDTH-1:0] cfg_core_sel_i,
  input  logic                          pll_lock_i,
  input  logic [RCU_CORE_SEL_WIDTH-1:0] core_sel_echo_i,
  output logic                          pll_en_o,
  output logic [RCU_CLK_CFG_WIDTH-1:0]  clk_cfg_o,
  output logic [RCU_CORE_SEL_WIDTH-1:0] core_sel_o,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          fail_o,
  output logic                          lock_o
);

  localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] SETTLE_LAST  = CNT_WIDTH'(SETTLE_CYC - 1);

  rcu_seq_state_e state_q, state_d;
  logic [CNT_WIDTH-1:0]          cnt_q, cnt_d;
  logic [RCU_CLK_CFG_WIDTH-1:0]  shadow_clk_q, shadow_clk_d;
  logic [RCU_CORE_SEL_WIDTH-1:0] shadow_sel_q, shadow_sel_d;
  logic                          pll_en_q, pll_en_d;
  logic [RCU_CLK_CFG_WIDTH-1:0]  clk_cfg_q, clk_cfg_d;
  logic [RCU_CORE_SEL_WIDTH-1:0] core_sel_q, core_sel_d;
  logic                          busy_q, busy_d;
  logic                          done_q, done_d;
  logic                          fail_q, fail_d;
  logic                          lock_q, lock_d;

  logic                          filt_clr;
  logic                          filt_lock;
  logic                          start_path;
  logic                          to_fail;
  logic [RCU_CLK_CFG_WIDTH-1:0]  path_clk;
  logic [RCU_CORE_SEL_WIDTH-1:0] path_sel;

  function automatic logic [CNT_WIDTH-1:0] cnt_inc(input logic [CNT_WIDTH-1:0] c);
    return (c == '1) ? c : c + CNT_WIDTH'(1);
  endfunction

  // The filter only accumulates while the sequencer is waiting for lock
  assign filt_clr = (state_q != ST_WAIT_LOCK);

  rcu_lock_filt #(
    .LOCK_FILT (LOCK_FILT)
  ) u_lock_filt (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .clr_i      (filt_clr),
    .lock_raw_i (pll_lock_i),
    .lock_o     (filt_lock)
  );

  // Next-state and registered-output computation
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shadow_clk_d = shadow_clk_q;
    shadow_sel_d = shadow_sel_q;
    pll_en_d     = pll_en_q;
    clk_cfg_d    = clk_cfg_q;
    core_sel_d   = core_sel_q;
    busy_d       = busy_q;
    done_d       = done_q;
    fail_d       = fail_q;
    lock_d       = lock_q;
    start_path   = 1'b0;
    to_fail      = 1'b0;
    path_clk     = shadow_clk_q;
    path_sel     = shadow_sel_q;

    case (state_q)
      ST_IDLE, ST_FAIL, ST_DONE: begin
        if (req_i) begin
          shadow_clk_d = cfg_clk_i;
          shadow_sel_d = cfg_core_sel_i;
          busy_d       = 1'b1;
          done_d       = 1'b0;
          fail_d       = 1'b0;
          cnt_d        = '0;
          if (state_q == ST_DONE) begin
            state_d    = ST_UNWIND;
            pll_en_d   = 1'b0;
            clk_cfg_d  = CLK_CFG_BYPASS;
            core_sel_d = '0;
            lock_d     = 1'b0;
          end else begin
            // Shadow registers load on this same edge, so take the path
            // choice straight from the request inputs.
            start_path = 1'b1;
            path_clk   = cfg_clk_i;
            path_sel   = cfg_core_sel_i;
          end
        end else if (state_q == ST_DONE && pll_used(shadow_clk_q) && !pll_lock_i) begin
          to_fail = 1'b1;
        end
      end

      ST_UNWIND: begin
        if (cnt_q == SETTLE_LAST) begin
          start_path = 1'b1;
        end else begin
          cnt_d = cnt_inc(cnt_q);
        end
      end

      ST_PLL_ON: begin
        state_d = ST_WAIT_LOCK;
        cnt_d   = '0;
      end

      ST_WAIT_LOCK: begin
        if (filt_lock) begin
          state_d    = ST_SWITCH;
          lock_d     = 1'b1;
          clk_cfg_d  = shadow_clk_q;
          core_sel_d = shadow_sel_q;
          cnt_d      = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          to_fail = 1'b1;
        end else begin
          cnt_d = cnt_inc(cnt_q);
        end
      end

      ST_SWITCH: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = ST_CONFIRM;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc(cnt_q);
        end
      end

      ST_CONFIRM: begin
        if (core_sel_echo_i == core_sel_q) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (cnt_q == SETTLE_LAST) begin
          to_fail = 1'b1;
        end else begin
          cnt_d = cnt_inc(cnt_q);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (start_path) begin
      cnt_d = '0;
      if (pll_used(path_clk)) begin
        state_d  = ST_PLL_ON;
        pll_en_d = 1'b1;
      end else begin
        state_d    = ST_SWITCH;
        pll_en_d   = 1'b0;
        clk_cfg_d  = path_clk;
        core_sel_d = path_sel;
      end
    end

    if (to_fail) begin
      state_d    = ST_FAIL;
      cnt_d      = '0;
      pll_en_d   = 1'b0;
      clk_cfg_d  = CLK_CFG_BYPASS;
      core_sel_d = '0;
      lock_d     = 1'b0;
      busy_d     = 1'b0;
      done_d     = 1'b0;
      fail_d     = 1'b1;
    end
  end

  // State, counter, shadow and output registers
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      shadow_clk_q <= CLK_CFG_BYPASS;
      shadow_sel_q <= '0;
      pll_en_q     <= 1'b0;
      clk_cfg_q    <= CLK_CFG_BYPASS;
      core_sel_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
      lock_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shadow_clk_q <= shadow_clk_d;
      shadow_sel_q <= shadow_sel_d;
      pll_en_q     <= pll_en_d;
      clk_cfg_q    <= clk_cfg_d;
      core_sel_q   <= core_sel_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      fail_q       <= fail_d;
      lock_q       <= lock_d;
    end
  end

  assign pll_en_o   = pll_en_q;
  assign clk_cfg_o  = clk_cfg_q;
  assign core_sel_o = core_sel_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign fail_o     = fail_q;
  assign lock_o     = lock_q;

endmodule

// File: tb/tb_rcu_cfg_seq.sv
// Bench for rcu_cfg_seq: behavioural reference model compared every cycle,
// directed scenarios with hand-computed timing, then randomized traffic.
module tb_rcu_cfg_seq;

  localparam int LOCK_TIMEOUT = 1024;
  localparam int LOCK_FILT    = 4;
  localparam int SETTLE_CYC   = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req;
  logic [2:0] cfg_clk;
  logic [4:0] cfg_sel;
  logic       lock;
  logic [4:0] echo = '0;
  logic       pll_en;
  logic [2:0] clk_cfg;
  logic [4:0] core_sel;
  logic       busy, done, fail, lock_o;

  always #5 clk = ~clk;

  rcu_cfg_seq #(
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .LOCK_FILT    (LOCK_FILT),
    .SETTLE_CYC   (SETTLE_CYC),
    .CNT_WIDTH    (16)
  ) dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .req_i           (req),
    .cfg_clk_i       (cfg_clk),
    .cfg_core_sel_i  (cfg_sel),
    .pll_lock_i      (lock),
    .core_sel_echo_i (echo),
    .pll_en_o        (pll_en),
    .clk_cfg_o       (clk_cfg),
    .core_sel_o      (core_sel),
    .busy_o          (busy),
    .done_o          (done),
    .fail_o          (fail),
    .lock_o          (lock_o)
  );

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // rcu_core stand-in: echoes core_sel back, or a forced value
  bit         echo_follow = 1'b1;
  logic [4:0] echo_forced = '0;
  always begin
    @(negedge clk);
    echo = echo_follow ? core_sel : echo_forced;
  end

  // ---------------- reference model ----------------
  typedef enum {M_IDLE, M_UNWIND, M_PLLON, M_WAIT, M_SWITCH, M_CONFIRM, M_DONE, M_FAIL} mph_e;
  mph_e       ph = M_IDLE;
  int         el = 0;     // cycles completed in the current phase
  int         run = 0;    // consecutive lock samples in the current wait
  logic [2:0] sh_clk = '0;
  logic [4:0] sh_sel = '0;
  logic       m_pll = 0, m_busy = 0, m_done = 0, m_fail = 0, m_lock = 0;
  logic [2:0] m_cfg = '0;
  logic [4:0] m_sel = '0;

  task automatic m_enter(input mph_e p);
    ph = p; el = 0; run = 0;
  endtask

  task automatic m_fail_now();
    m_pll = 0; m_cfg = '0; m_sel = '0; m_lock = 0;
    m_busy = 0; m_done = 0; m_fail = 1;
    m_enter(M_FAIL);
  endtask

  task automatic m_begin_path();
    if (sh_clk == 3'b000) begin
      m_cfg = 3'b000; m_sel = sh_sel; m_enter(M_SWITCH);
    end else begin
      m_pll = 1; m_enter(M_PLLON);
    end
  endtask

  always begin
    @(posedge clk);
    if (!rst_n) begin
      m_pll = 0; m_cfg = '0; m_sel = '0; m_busy = 0; m_done = 0; m_fail = 0; m_lock = 0;
      sh_clk = '0; sh_sel = '0;
      m_enter(M_IDLE);
    end else begin
      el++;
      case (ph)
        M_IDLE, M_FAIL, M_DONE: begin
          if (req) begin
            sh_clk = cfg_clk; sh_sel = cfg_sel;
            m_busy = 1; m_done = 0; m_fail = 0;
            if (ph == M_DONE) begin
              m_pll = 0; m_cfg = '0; m_sel = '0; m_lock = 0;
              m_enter(M_UNWIND);
            end else begin
              m_begin_path();
            end
          end else if (ph == M_DONE && sh_clk != 3'b000 && !lock) begin
            m_fail_now();
          end
        end
        M_UNWIND:  if (el >= SETTLE_CYC) m_begin_path();
        M_PLLON:   m_enter(M_WAIT);
        M_WAIT: begin
          run = lock ? run + 1 : 0;
          if (run >= LOCK_FILT) begin
            m_lock = 1; m_cfg = sh_clk; m_sel = sh_sel;
            m_enter(M_SWITCH);
          end else if (el >= LOCK_TIMEOUT) begin
            m_fail_now();
          end
        end
        M_SWITCH:  if (el >= SETTLE_CYC) m_enter(M_CONFIRM);
        M_CONFIRM: begin
          if (echo == m_sel) begin
            m_busy = 0; m_done = 1; m_enter(M_DONE);
          end else if (el >= SETTLE_CYC) begin
            m_fail_now();
          end
        end
        default: ;
      endcase
    end
  end

  // Every-cycle comparison of all outputs against the model
  always begin
    @(negedge clk);
    if (cmp_en) begin
      checks++;
      if ({pll_en, clk_cfg, core_sel, busy, done, fail, lock_o} !==
          {m_pll, m_cfg, m_sel, m_busy, m_done, m_fail, m_lock}) begin
        errors++;
        $display("FAIL cycle_compare t=%0t got pll=%b cfg=%0h sel=%0h busy=%b done=%b fail=%b lock=%b expected pll=%b cfg=%0h sel=%0h busy=%b done=%b fail=%b lock=%b",
                 $time, pll_en, clk_cfg, core_sel, busy, done, fail, lock_o,
                 m_pll, m_cfg, m_sel, m_busy, m_done, m_fail, m_lock);
      end
    end
  end

  // ---------------- directed helpers ----------------
  function automatic int outs();
    return int'({pll_en, clk_cfg, core_sel, busy, done, fail, lock_o});
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic issue(input logic [2:0] c, input logic [4:0] s);
    cfg_clk = c; cfg_sel = s; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
  endtask

  // k counts edges after the accepting edge; waits for done (or fail) high
  task automatic wait_rise(input string name, input bit want_fail, input int budget,
                           inout int k, output bit pll_seen);
    pll_seen = pll_en;
    while (!(want_fail ? fail : done)) begin
      if (k >= budget) begin
        checks++; errors++;
        $display("FAIL %s: no rise within %0d cycles", name, budget);
        return;
      end
      @(negedge clk);
      k++;
      pll_seen |= pll_en;
    end
  endtask

  task automatic reset_dut();
    rst_n = 1'b0; req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int k;
    bit pseen;
    int stuck;
    logic pat [7];
    pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

    rst_n = 1'b0; req = 1'b0; cfg_clk = '0; cfg_sel = '0; lock = 1'b0;
    @(negedge clk);
    cmp_en = 1'b1;
    @(negedge clk);
    chk("reset_outputs", outs(), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // PLL path: lock sampled high from the 5th edge after accept.
    // 1 PLL_ON + 7 WAIT_LOCK (3 unlocked + 4 filter) + 16 SWITCH + 1 CONFIRM = 25
    issue(3'b011, 5'h02);
    k = 0;
    repeat (4) begin @(negedge clk); k++; end
    lock = 1'b1;
    wait_rise("pll_done", 1'b0, 200, k, pseen);
    chk("pll_done_latency", k, 25);
    chk("model_done_pinned", int'(m_done), 1);
    chk("pll_done_outputs", outs(), int'({1'b1, 3'b011, 5'h02, 1'b0, 1'b1, 1'b0, 1'b1}));

    // Lock drops for one cycle while DONE on the PLL -> FAIL
    lock = 1'b0;
    @(negedge clk);
    lock = 1'b1;
    chk("done_lock_drop", outs(), int'({1'b0, 3'b000, 5'h00, 1'b0, 1'b0, 1'b1, 1'b0}));

    // Glitching lock 1,1,0,1,1,1,1 on the WAIT_LOCK samples
    lock = 1'b0;
    issue(3'b110, 5'h11);
    k = 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk); k++;
      lock = pat[i];
    end
    chk("glitch_lock_before_run", int'(lock_o), 0);
    @(negedge clk); k++;
    chk("glitch_lock_after_run", int'(lock_o), 1);
    wait_rise("glitch_done", 1'b0, 200, k, pseen);
    chk("glitch_done_latency", k, 25);

    // Lock stuck low: fail on edge 1 + LOCK_TIMEOUT after accept
    reset_dut();
    lock = 1'b0;
    issue(3'b011, 5'h02);
    k = 0;
    wait_rise("timeout_fail", 1'b1, 1200, k, pseen);
    chk("timeout_latency", k, 1 + LOCK_TIMEOUT);
    chk("model_fail_pinned", int'(m_fail), 1);
    chk("timeout_outputs", outs(), int'({1'b0, 3'b000, 5'h00, 1'b0, 1'b0, 1'b1, 1'b0}));

    // Bypass request from FAIL: SETTLE_CYC in SWITCH + 1 CONFIRM, PLL never on
    issue(3'b000, 5'h07);
    k = 0;
    wait_rise("bypass_done", 1'b0, 100, k, pseen);
    chk("bypass_latency", k, SETTLE_CYC + 1);
    chk("bypass_pll_never_on", int'(pseen), 0);
    chk("bypass_outputs", outs(), int'({1'b0, 3'b000, 5'h07, 1'b0, 1'b1, 1'b0, 1'b0}));

    // Echo never matches: 16 UNWIND + 1 PLL_ON + 4 WAIT + 16 SWITCH + 16 CONFIRM = 53
    echo_follow = 1'b0; echo_forced = 5'h00; lock = 1'b1;
    issue(3'b001, 5'h05);
    k = 0;
    wait_rise("echo_fail", 1'b1, 200, k, pseen);
    chk("echo_fail_latency", k, 53);
    chk("echo_fail_outputs", outs(), int'({1'b0, 3'b000, 5'h00, 1'b0, 1'b0, 1'b1, 1'b0}));
    echo_follow = 1'b1;

    // Reset in the middle of WAIT_LOCK
    lock = 1'b0;
    issue(3'b100, 5'h01);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("reset_mid_wait", outs(), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // New request while in SWITCH must be ignored
    lock = 1'b1;
    issue(3'b011, 5'h02);
    k = 0;
    while (clk_cfg != 3'b011 && k < 40) begin @(negedge clk); k++; end
    chk("switch_reached", int'(clk_cfg), 3);
    cfg_clk = 3'b101; cfg_sel = 5'h1f; req = 1'b1;
    repeat (3) begin @(negedge clk); k++; end
    req = 1'b0;
    wait_rise("busy_req_done", 1'b0, 200, k, pseen);
    chk("busy_req_latency", k, 22);
    chk("busy_req_cfg_kept", int'({clk_cfg, core_sel}), int'({3'b011, 5'h02}));

    // Randomized traffic against the model
    stuck = 0;
    for (int i = 0; i < 4000; i++) begin
      req     = ($urandom_range(0, 39) == 0);
      cfg_clk = ($urandom_range(0, 3) == 0) ? 3'b000 : 3'($urandom_range(1, 7));
      cfg_sel = 5'($urandom);
      if (stuck == 0 && $urandom_range(0, 299) == 0) stuck = $urandom_range(20, 1200);
      if (stuck > 0) begin
        lock = 1'b0;
        stuck--;
      end else begin
        lock = ($urandom_range(0, 49) != 0);
      end
      echo_follow = ($urandom_range(0, 19) != 0);
      echo_forced = 5'($urandom);
      rst_n       = ($urandom_range(0, 1499) != 0);
      @(negedge clk);
    end
    rst_n = 1'b1; req = 1'b0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
